// File: rtl/branch_history_predictor_if.sv
// Decode-lookup, execute-resolve and statistics signals of branch_history_predictor.
// master = pipeline side driving lookups/resolves, slave = the predictor.
interface branch_history_predictor_if;
  logic [31:0] lookup_pc;
  logic        lookup_isBranch;
  logic        predict_taken;
  logic        resolve_valid;
  logic [31:0] resolve_pc;
  logic        resolve_taken;
  logic        resolve_predicted;
  logic [31:0] resolve_target;
  logic [31:0] resolve_fallthrough;
  logic        mispredict;
  logic [31:0] recover_pc;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  // resolve_valid is a qualifier, not a handshake: the predictor always accepts a resolve in the
  // cycle it is presented, and mispredict/recover_pc appear exactly one cycle later.
  modport master (
    output lookup_pc, lookup_isBranch, resolve_valid, resolve_pc, resolve_taken,
           resolve_predicted, resolve_target, resolve_fallthrough,
    input  predict_taken, mispredict, recover_pc, branch_count, mispredict_count
  );

  modport slave (
    input  lookup_pc, lookup_isBranch, resolve_valid, resolve_pc, resolve_taken,
           resolve_predicted, resolve_target, resolve_fallthrough,
    output predict_taken, mispredict, recover_pc, branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_history_predictor.sv
// Saturating-counter branch predictor with registered mispredict flush and statistics.
// Optional gshare indexing is enabled by defining GSHARE_EN.
module branch_history_predictor #(
  parameter int INDEX_BITS = 6,
  parameter int CTR_BITS   = 2,
  parameter int HIST_BITS  = 6
) (
  input logic                       clock,
  input logic                       reset,
  branch_history_predictor_if.slave bp
);
  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_INIT = {1'b0, {(CTR_BITS-1){1'b1}}};
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};

  logic [CTR_BITS-1:0]   table_q [ENTRIES];
  logic [INDEX_BITS-1:0] rd_idx, wr_idx;
  logic [CTR_BITS-1:0]   ctr_cur, ctr_d;
  logic                  mispredict_q, mispredict_d;
  logic [31:0]           recover_pc_q, recover_pc_d;
  logic [31:0]           branch_count_q, branch_count_d;
  logic [31:0]           mispredict_count_q, mispredict_count_d;
  logic                  unused_pc_bits;

  assign unused_pc_bits = ^{bp.lookup_pc[31:INDEX_BITS], bp.resolve_pc[31:INDEX_BITS]};

`ifdef GSHARE_EN
  logic [HIST_BITS-1:0]  hist_q, hist_d;
  logic [INDEX_BITS-1:0] hist_idx;

  // The write index uses hist_q, i.e. the history as it was before this resolve shifts in.
  assign hist_idx = INDEX_BITS'(hist_q);
  assign rd_idx   = bp.lookup_pc[INDEX_BITS-1:0] ^ hist_idx;
  assign wr_idx   = bp.resolve_pc[INDEX_BITS-1:0] ^ hist_idx;
  assign hist_d   = bp.resolve_valid ? ((hist_q << 1) | HIST_BITS'(bp.resolve_taken)) : hist_q;

  always_ff @(posedge clock) begin
    if (reset) hist_q <= '0;
    else       hist_q <= hist_d;
  end
`else
  localparam int hist_bits_unused = HIST_BITS;

  assign rd_idx = bp.lookup_pc[INDEX_BITS-1:0];
  assign wr_idx = bp.resolve_pc[INDEX_BITS-1:0];
`endif

  // No bypass: a same-cycle lookup of the entry being trained sees the old count.
  assign bp.predict_taken = table_q[rd_idx][CTR_BITS-1] & bp.lookup_isBranch;

  always_comb begin
    ctr_cur = table_q[wr_idx];
    ctr_d   = ctr_cur;
    if (bp.resolve_taken) begin
      if (ctr_cur != CTR_MAX) ctr_d = ctr_cur + 1'b1;
    end else begin
      if (ctr_cur != '0) ctr_d = ctr_cur - 1'b1;
    end
  end

  always_comb begin
    mispredict_d       = bp.resolve_valid & (bp.resolve_taken != bp.resolve_predicted);
    recover_pc_d       = recover_pc_q;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (mispredict_d)
      recover_pc_d = bp.resolve_taken ? bp.resolve_target : bp.resolve_fallthrough;
    if (bp.resolve_valid && branch_count_q != 32'hFFFF_FFFF)
      branch_count_d = branch_count_q + 32'd1;
    if (mispredict_d && mispredict_count_q != 32'hFFFF_FFFF)
      mispredict_count_d = mispredict_count_q + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= CTR_INIT;
    end else if (bp.resolve_valid) begin
      table_q[wr_idx] <= ctr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mispredict_q       <= 1'b0;
      recover_pc_q       <= '0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      mispredict_q       <= mispredict_d;
      recover_pc_q       <= recover_pc_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign bp.mispredict       = mispredict_q;
  assign bp.recover_pc       = recover_pc_q;
  assign bp.branch_count     = branch_count_q;
  assign bp.mispredict_count = mispredict_count_q;
endmodule

// File: tb/tb_branch_history_predictor.sv
// Bench for branch_history_predictor: per-cycle comparison against a table model plus
// hand-computed directed expectations.
module tb_branch_history_predictor;
  localparam int IB   = 6;
  localparam int CB   = 2;
  localparam int NENT = 1 << IB;
  localparam int CMAX = (1 << CB) - 1;
  localparam int HALF = 1 << (CB - 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_history_predictor_if bif ();

  branch_history_predictor #(.INDEX_BITS(IB), .CTR_BITS(CB), .HIST_BITS(6)) dut (
    .clock(clk),
    .reset(rst),
    .bp   (bif)
  );

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int          m_ctr [NENT];
  bit          m_mis;
  logic [31:0] m_rec;
  longint      m_bc, m_mc;
  int          m_hist;
  bit          model_ready = 1'b0;

  function automatic int tbl_index(input logic [31:0] pc);
    int base;
    base = int'(pc % NENT);
`ifdef GSHARE_EN
    return base ^ (m_hist % NENT);
`else
    return base;
`endif
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NENT; i++) m_ctr[i] = HALF - 1;
      m_mis = 0; m_rec = 0; m_bc = 0; m_mc = 0; m_hist = 0;
      model_ready = 1'b1;
    end else begin
      m_mis = bif.resolve_valid && (bif.resolve_taken != bif.resolve_predicted);
      if (m_mis) m_rec = bif.resolve_taken ? bif.resolve_target : bif.resolve_fallthrough;
      if (bif.resolve_valid) begin
        int w;
        w = tbl_index(bif.resolve_pc);
        if (bif.resolve_taken) m_ctr[w] = (m_ctr[w] + 1 > CMAX) ? CMAX : m_ctr[w] + 1;
        else                   m_ctr[w] = (m_ctr[w] - 1 < 0) ? 0 : m_ctr[w] - 1;
        if (m_bc < 64'hFFFF_FFFF) m_bc++;
        if (m_mis && m_mc < 64'hFFFF_FFFF) m_mc++;
        m_hist = (m_hist * 2 + int'(bif.resolve_taken)) % 64;
      end
    end
  end

  // ---------------- scoreboard compare (every cycle, on the falling edge) ----------------
  always @(negedge clk) begin
    if (model_ready) begin
      check("cyc_predict", {31'd0, bif.predict_taken},
            {31'd0, (bif.lookup_isBranch && m_ctr[tbl_index(bif.lookup_pc)] >= HALF)});
      check("cyc_mispredict", {31'd0, bif.mispredict}, {31'd0, m_mis});
      check("cyc_recover_pc", bif.recover_pc, m_rec);
      check("cyc_branch_count", bif.branch_count, m_bc[31:0]);
      check("cyc_mispredict_count", bif.mispredict_count, m_mc[31:0]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic taken, input logic pred,
                         input logic [31:0] tgt, input logic [31:0] fall);
    bif.resolve_valid       = 1'b1;
    bif.resolve_pc          = pc;
    bif.resolve_taken       = taken;
    bif.resolve_predicted   = pred;
    bif.resolve_target      = tgt;
    bif.resolve_fallthrough = fall;
  endtask

  task automatic lookup(input logic [31:0] pc, input logic is_br);
    bif.lookup_pc       = pc;
    bif.lookup_isBranch = is_br;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1;
    lookup(32'h0, 1'b0);
    resolve(32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    bif.resolve_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;

`ifndef GSHARE_EN
    lookup(32'h05, 1'b1);
    #1;
    check("reset_predict", {31'd0, bif.predict_taken}, 32'd0);
    check("reset_mispredict", {31'd0, bif.mispredict}, 32'd0);
    check("reset_branch_count", bif.branch_count, 32'd0);
    check("reset_mispredict_count", bif.mispredict_count, 32'd0);

    resolve(32'h05, 1'b1, 1'b0, 32'h40, 32'h06);
    tick(); bif.resolve_valid = 1'b0; #1;
    check("first_mispredict", {31'd0, bif.mispredict}, 32'd1);
    check("first_recover_pc", bif.recover_pc, 32'h40);
    check("first_trained_predict", {31'd0, bif.predict_taken}, 32'd1);
    check("first_branch_count", bif.branch_count, 32'd1);
    check("first_mispredict_count", bif.mispredict_count, 32'd1);
    tick(); #1;
    check("pulse_one_cycle", {31'd0, bif.mispredict}, 32'd0);
    check("recover_pc_holds", bif.recover_pc, 32'h40);

    repeat (4) begin resolve(32'h05, 1'b1, 1'b1, 32'h40, 32'h06); tick(); end
    resolve(32'h05, 1'b0, 1'b1, 32'h40, 32'h06);
    tick(); bif.resolve_valid = 1'b0; #1;
    check("sat_one_down_predict", {31'd0, bif.predict_taken}, 32'd1);
    check("nt_mispredict_pulse", {31'd0, bif.mispredict}, 32'd1);
    check("nt_recover_pc", bif.recover_pc, 32'h06);
    resolve(32'h05, 1'b0, 1'b0, 32'h40, 32'h06);
    tick(); bif.resolve_valid = 1'b0; #1;
    check("sat_two_down_predict", {31'd0, bif.predict_taken}, 32'd0);
    check("sat_branch_count", bif.branch_count, 32'd7);
    check("sat_mispredict_count", bif.mispredict_count, 32'd2);

    resolve(32'h05, 1'b1, 1'b0, 32'h40, 32'h06); tick();
    resolve(32'h05, 1'b1, 1'b1, 32'h40, 32'h06); tick();
    bif.resolve_valid = 1'b0;
    lookup(32'h45, 1'b1); #1;
    check("alias_predict", {31'd0, bif.predict_taken}, 32'd1);
    lookup(32'h45, 1'b0); #1;
    check("not_branch_predict", {31'd0, bif.predict_taken}, 32'd0);

    resolve(32'h10, 1'b1, 1'b0, 32'h100, 32'h11); tick(); #1;
    check("b2b_first_recover", bif.recover_pc, 32'h100);
    resolve(32'h11, 1'b0, 1'b1, 32'h200, 32'h12); tick(); bif.resolve_valid = 1'b0; #1;
    check("b2b_second_pulse", {31'd0, bif.mispredict}, 32'd1);
    check("b2b_second_recover", bif.recover_pc, 32'h12);
    tick(); #1;
    check("b2b_pulse_ends", {31'd0, bif.mispredict}, 32'd0);

    rst = 1'b1; tick(); rst = 1'b0;
    lookup(32'h05, 1'b1);
    resolve(32'h05, 1'b1, 1'b0, 32'h40, 32'h06); #1;
    check("same_cycle_old_value", {31'd0, bif.predict_taken}, 32'd0);
    tick(); bif.resolve_valid = 1'b0; #1;
    check("same_cycle_next_value", {31'd0, bif.predict_taken}, 32'd1);

    resolve(32'h09, 1'b0, 1'b1, 32'h80, 32'h06);
    rst = 1'b1;
    tick(); rst = 1'b0; bif.resolve_valid = 1'b0; #1;
    check("reset_drops_pulse", {31'd0, bif.mispredict}, 32'd0);
    check("reset_clears_branch_count", bif.branch_count, 32'd0);
    check("reset_clears_mispredict_count", bif.mispredict_count, 32'd0);
`else
    resolve(32'h00, 1'b1, 1'b1, 32'h10, 32'h01); tick();
    resolve(32'h01, 1'b1, 1'b1, 32'h10, 32'h02); tick();
    bif.resolve_valid = 1'b0;
    lookup(32'h03, 1'b1); #1;
    check("gshare_lookup_index0", {31'd0, bif.predict_taken}, 32'd1);
    lookup(32'h00, 1'b1); #1;
    check("gshare_lookup_index3", {31'd0, bif.predict_taken}, 32'd0);
`endif

    // Directed sweep over many PCs; the per-cycle scoreboard checks it against the model.
    for (int i = 0; i < 40; i++) begin
      lookup(32'((i * 5) % 128), 1'(i % 7 != 0));
      if (i % 4 != 3)
        resolve(32'((i * 13) % 128), 1'((i / 2) % 3 != 0), 1'(i % 2),
                32'(32'h300 + i), 32'(32'h400 + i));
      else
        bif.resolve_valid = 1'b0;
      tick();
    end
    bif.resolve_valid = 1'b0;
    tick(); tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/branch_history_predictor.md
# branch_history_predictor

Parametrised dynamic branch predictor for the five-stage pipeline. It replaces the static `branchPredictedTaken` input to the decode stage with a table of saturating counters, indexed by word PC. The table is read in decode and trained at branch resolution in execute. It also generates the registered mispredict flush and recovery PC, and keeps branch and mispredict statistics.

## Interface
Parameters:
- INDEX_BITS, 6, log2 of table entries (64 by default)
- CTR_BITS, 2, counter width (2 or more)
- HIST_BITS, 6, global history length (only used with GSHARE_EN; must be INDEX_BITS or fewer)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- lookup_pc  in  32  word PC of the instruction in decode
- lookup_isBranch  in  1  decode instruction is bne, blt or bex
- predict_taken  out  1  prediction for the decode branch
- resolve_valid  in  1  a branch resolved in execute this cycle
- resolve_pc  in  32  word PC of the resolved branch
- resolve_taken  in  1  actual outcome
- resolve_predicted  in  1  prediction carried down the pipe with the branch
- resolve_target  in  32  taken target (pc+1+sei)
- resolve_fallthrough  in  32  not-taken PC (pc+1)
- mispredict  out  1  registered one-cycle flush pulse
- recover_pc  out  32  registered redirect PC, valid while mispredict=1
- branch_count  out  32  resolved branches since reset
- mispredict_count  out  32  mispredicts since reset

## Operation
- Table: 2^INDEX_BITS counters, each CTR_BITS wide, held in flops.
- Read index = lookup_pc[INDEX_BITS-1:0].
- predict_taken = MSB of the indexed counter AND lookup_isBranch. It is combinational from table state.
- Write index = resolve_pc[INDEX_BITS-1:0].
- Training happens on resolve_valid:
  - resolve_taken=1: counter +1, saturating at 2^CTR_BITS-1.
  - resolve_taken=0: counter -1, saturating at 0.
- Mispredict: resolve_valid AND (resolve_taken != resolve_predicted).
  - Registered into mispredict.
  - recover_pc registers resolve_target if taken, else resolve_fallthrough.
- When there is no mispredict, mispredict=0 and recover_pc holds its last value.
- Statistics:
  - branch_count +1 on each resolve_valid.
  - mispredict_count +1 on each mispredict.
  - Both saturate at 0xFFFFFFFF and never wrap.
- Aliasing is permitted: PCs that are equal modulo 2^INDEX_BITS share one entry. There are no tags.

## Timing
- Reset values:
  - every counter = 2^(CTR_BITS-1)-1 (weakly not-taken; 01 for CTR_BITS=2)
  - mispredict=0, recover_pc=0, branch_count=0, mispredict_count=0
  - history register = 0
- Reset has priority over every update in the same cycle.
- A reset asserted mid-operation discards any pending mispredict pulse on the next edge.
- Prediction latency: 0 cycles, same cycle as lookup_pc.
- Training latency: the counter updates at the edge ending the resolve cycle, so a lookup of the same index in the next cycle sees the new value.
- Same-cycle lookup and resolve on the same index: the lookup sees the old value. There is no bypass.
- mispredict is high for exactly the cycle after the resolve cycle.
- Back-to-back mispredicts in consecutive cycles give consecutive pulses, each carrying its own recover_pc.
- Mispredict is flagged regardless of downstream flush state; squashing wrong-path resolves is the execute stage's job (it deasserts resolve_valid).

## Configuration
- GSHARE_EN defined:
  - A HIST_BITS global history register shifts left at every resolve_valid edge, with resolve_taken inserted at bit 0.
  - Both read and write indices become pc[INDEX_BITS-1:0] XOR {zero-extended history}.
  - The write index uses the history value from before the shift.
  - History is updated non-speculatively, at resolution only.
- GSHARE_EN undefined:
  - No history register; indexing is PC only.
  - HIST_BITS is ignored.

## Test plan
- Reset, then lookup_pc=0x05, lookup_isBranch=1 -> predict_taken=0; all counts 0; mispredict=0.
- One resolve at pc=0x05 (taken=1, predicted=0, target=0x40) -> next cycle mispredict=1, recover_pc=0x40, predict_taken=1 at 0x05; cycle after, mispredict=0; branch_count=1, mispredict_count=1.
- Saturation, CTR_BITS=2: four taken resolves at 0x05, then one not-taken -> counter 10, predict_taken=1; a further not-taken -> predict_taken=0.
- Aliasing, INDEX_BITS=6: train 0x05 taken twice -> lookup 0x45 predicts taken. Same-cycle lookup/resolve at 0x05 from reset state -> predict_taken=0 that cycle, 1 the next.
- Not-taken mispredict (taken=0, predicted=1, fallthrough=0x06) -> recover_pc=0x06. Assert reset in the resolve cycle -> mispredict stays 0 and counts return to 0.
- GSHARE_EN: resolve 0x00 taken, then 0x01 taken -> history=0b11; lookup 0x03 uses index 0x00.
